// File: rtl/noc_flit_tx.sv
// noc_flit_tx -- injection-side flit transmitter for the NoC crossbar.
//
// Turns a packet request (dest, len) plus a stream of payload words into
// typed flits (HEAD/BODY/TAIL/HEADTAIL). Flits are sent toward one crossbar
// input port under credit-based flow control. There is one output register
// stage, so a request or word accepted at edge N appears on flit_out during
// cycle N+1.
//
// Optional feature macro: NOC_TX_PARITY_EN
//   When defined, flit_out gains bit [DATA_W+2]. It holds even parity over
//   {type, payload} and is computed when the flit is registered.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-low reset
//   req_valid/ready    packet request handshake; req_dest, req_len fields
//   data_valid/ready   payload word handshake; data_in word
//   flit_valid         flit present on flit_out this cycle (no backpressure)
//   flit_out           {[parity], type[1:0], payload[DATA_W-1:0]}
//                      type 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL
//   credit_ret         one pulse per downstream buffer slot freed
//   busy               multi-flit packet in progress (BODY state)

module noc_flit_tx #(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 4,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DEST_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              flit_valid,
`ifdef NOC_TX_PARITY_EN
    output logic [DATA_W+2:0] flit_out,
`else
    output logic [DATA_W+1:0] flit_out,
`endif
    input  logic              credit_ret,
    output logic              busy
);

    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [1:0] T_HEAD     = 2'b00;
    localparam logic [1:0] T_BODY     = 2'b01;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    typedef struct packed {
        logic [1:0]        ftype;
        logic [DATA_W-1:0] payload;
    } flit_t;

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  remaining, rem_nxt;
    logic [CW-1:0]     credit_cnt;
    logic              can_send;
    logic              flit_load;
    flit_t             flit_q, flit_nxt;
    logic [DATA_W-1:0] head_pl;

    // The send decision only looks at the registered count. A credit that
    // returns this cycle cannot enable a send until the next cycle.
    assign can_send = (credit_cnt != '0);
    assign busy     = (state == BODY);

    always_comb begin
        head_pl = '0;
        head_pl[DEST_W-1:0]            = req_dest;
        head_pl[DEST_W+LEN_W-1:DEST_W] = req_len;
    end

    always_comb begin
        state_nxt  = state;
        rem_nxt    = remaining;
        flit_load  = 1'b0;
        flit_nxt   = '0;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = can_send;
                if (req_valid && can_send) begin
                    flit_load        = 1'b1;
                    flit_nxt.payload = head_pl;
                    if (req_len == '0) begin
                        flit_nxt.ftype = T_HEADTAIL;
                    end else begin
                        flit_nxt.ftype = T_HEAD;
                        rem_nxt        = req_len;
                        state_nxt      = BODY;
                    end
                end
            end
            BODY: begin
                data_ready = can_send;
                if (data_valid && can_send) begin
                    flit_load        = 1'b1;
                    flit_nxt.payload = data_in;
                    rem_nxt          = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        flit_nxt.ftype = T_TAIL;
                        state_nxt      = IDLE;
                    end else begin
                        flit_nxt.ftype = T_BODY;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            credit_cnt <= CW'(CREDITS);
            flit_valid <= 1'b0;
            flit_q     <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= rem_nxt;
            flit_valid <= flit_load;
            if (flit_load)
                flit_q <= flit_nxt;
            // A send and a return in the same cycle cancel out. A return
            // arriving while the count is full is dropped.
            if (flit_load && !credit_ret)
                credit_cnt <= credit_cnt - CW'(1);
            else if (!flit_load && credit_ret && credit_cnt != CW'(CREDITS))
                credit_cnt <= credit_cnt + CW'(1);
        end
    end

`ifdef NOC_TX_PARITY_EN
    logic flit_par;

    always_ff @(posedge clk) begin
        if (!rst)
            flit_par <= 1'b0;
        else if (flit_load)
            flit_par <= ^flit_nxt;
    end

    assign flit_out = {flit_par, flit_q};
`else
    assign flit_out = flit_q;
`endif

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed bench for noc_flit_tx (DATA_W=32, DEST_W=4, LEN_W=4, CREDITS=4).
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// right after the inputs are driven. Registered outputs then reflect the edge
// just passed, and the handshake readies reflect the current inputs.
module tb_noc_flit_tx;

`ifdef NOC_TX_PARITY_EN
    localparam int FW = 35;
`else
    localparam int FW = 34;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [3:0]    req_dest, req_len;
    logic          data_valid, data_ready;
    logic [31:0]   data_in;
    logic          flit_valid;
    logic [FW-1:0] flit_out;
    logic          credit_ret;
    logic          busy;

    int checks = 0;
    int errors = 0;

    noc_flit_tx dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .flit_valid (flit_valid),
        .flit_out   (flit_out),
        .credit_ret (credit_ret),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
        logic [33:0] f;
        f = {t, p};
`ifdef NOC_TX_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 0; req_dest = 0; req_len = 0;
        data_valid = 0; data_in = 0; credit_ret = 0;
        step(); step();
        rst = 1'b1;
        #1;
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL reset_flit_valid got %b want 0", flit_valid); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit_out got %h want 0", flit_out); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0 || data_ready !== 1'b0) begin errors++; $display("FAIL reset_busy_dready got %b%b want 00", busy, data_ready); end
        checks++; if (dut.credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d want 4", dut.credit_cnt); end
        step();
    endtask

    task automatic test_multi_flit();
        logic [31:0] words [3];
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        req_valid = 1; req_dest = 4'd5; req_len = 4'd3;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mf_req_ready got %b want 1", req_ready); end
        step();
        req_valid = 0;
        checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b00, 32'h35)) begin errors++; $display("FAIL mf_head got %b/%h want 1/%h", flit_valid, flit_out, mk(2'b00, 32'h35)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mf_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1; data_in = words[i]; credit_ret = flit_valid;
            step();
            checks++;
            if (flit_valid !== 1'b1 || flit_out !== mk(i == 2 ? 2'b10 : 2'b01, words[i])) begin
                errors++; $display("FAIL mf_word%0d got %b/%h want 1/%h", i, flit_valid, flit_out, mk(i == 2 ? 2'b10 : 2'b01, words[i]));
            end
        end
        data_valid = 0; credit_ret = 1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mf_busy_end got %b want 0", busy); end
        step();
        credit_ret = 0;
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL mf_idle_valid got %b want 0", flit_valid); end
        checks++; if (flit_out !== mk(2'b10, 32'hC)) begin errors++; $display("FAIL mf_hold got %h want %h", flit_out, mk(2'b10, 32'hC)); end
        checks++; if (dut.credit_cnt !== 3'd4) begin errors++; $display("FAIL mf_credits got %0d want 4", dut.credit_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] dests [4];
        dests[0] = 1; dests[1] = 2; dests[2] = 3; dests[3] = 4;
        req_len = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_dest = dests[i];
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, req_ready); end
            step();
            checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b11, {28'd0, dests[i]})) begin errors++; $display("FAIL b2b_flit%0d got %b/%h want 1/%h", i, flit_valid, flit_out, mk(2'b11, {28'd0, dests[i]})); end
        end
        req_dest = 4'd6;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_noready got %b want 0", req_ready); end
        step();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL b2b_stall_valid got %b want 0", flit_valid); end
        credit_ret = 1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ret_same_cycle got %b want 0", req_ready); end
        step();
        credit_ret = 0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_ret got %b want 1", req_ready); end
        step();
        req_valid = 0;
        checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b11, 32'h6)) begin errors++; $display("FAIL b2b_flit5 got %b/%h want 1/%h", flit_valid, flit_out, mk(2'b11, 32'h6)); end
        credit_ret = 1;
        repeat (4) step();
        credit_ret = 0;
        checks++; if (dut.credit_cnt !== 3'd4) begin errors++; $display("FAIL b2b_credits got %0d want 4", dut.credit_cnt); end
    endtask

    task automatic test_credit_stall();
        req_valid = 1; req_dest = 4'd2; req_len = 4'd6;
        step();
        req_valid = 0;
        checks++; if (flit_out !== mk(2'b00, 32'h62)) begin errors++; $display("FAIL cs_head got %h want %h", flit_out, mk(2'b00, 32'h62)); end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1; data_in = 32'h100 + 32'(i);
            step();
            checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b01, 32'h100 + 32'(i))) begin errors++; $display("FAIL cs_body%0d got %b/%h want 1/%h", i, flit_valid, flit_out, mk(2'b01, 32'h100 + 32'(i))); end
        end
        data_in = 32'h103;
        #1;
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL cs_dready_low got %b want 0", data_ready); end
        step();
        checks++; if (flit_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cs_stalled got valid %b busy %b want 0 1", flit_valid, busy); end
        data_valid = 0; credit_ret = 1;
        step(); step();
        credit_ret = 0;
        checks++; if (dut.credit_cnt !== 3'd2) begin errors++; $display("FAIL cs_credits2 got %0d want 2", dut.credit_cnt); end
        for (int i = 3; i < 5; i++) begin
            data_valid = 1; data_in = 32'h100 + 32'(i);
            step();
            checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b01, 32'h100 + 32'(i))) begin errors++; $display("FAIL cs_resume%0d got %b/%h want 1/%h", i, flit_valid, flit_out, mk(2'b01, 32'h100 + 32'(i))); end
        end
        data_in = 32'h105;
        step();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL cs_only_two got %b want 0", flit_valid); end
        credit_ret = 1;
        step();
        credit_ret = 0;
        step();
        data_valid = 0;
        checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b10, 32'h105) || busy !== 1'b0) begin errors++; $display("FAIL cs_tail got %b/%h busy %b want 1/%h busy 0", flit_valid, flit_out, busy, mk(2'b10, 32'h105)); end
        credit_ret = 1;
        repeat (4) step();
        credit_ret = 0;
        checks++; if (dut.credit_cnt !== 3'd4) begin errors++; $display("FAIL cs_credits4 got %0d want 4", dut.credit_cnt); end
    endtask

    task automatic test_credit_edges();
        req_valid = 1; req_len = 0; req_dest = 4'd8;
        step(); step();
        credit_ret = 1; req_dest = 4'd9;
        #1;
        checks++; if (dut.credit_cnt !== 3'd2) begin errors++; $display("FAIL ce_pre got %0d want 2", dut.credit_cnt); end
        step();
        req_valid = 0; credit_ret = 0;
        checks++; if (dut.credit_cnt !== 3'd2) begin errors++; $display("FAIL ce_simul got %0d want 2", dut.credit_cnt); end
        checks++; if (flit_out !== mk(2'b11, 32'h9)) begin errors++; $display("FAIL ce_flit got %h want %h", flit_out, mk(2'b11, 32'h9)); end
        credit_ret = 1;
        step(); step(); step();
        credit_ret = 0;
        checks++; if (dut.credit_cnt !== 3'd4 || flit_valid !== 1'b0) begin errors++; $display("FAIL ce_saturate got %0d valid %b want 4 valid 0", dut.credit_cnt, flit_valid); end
    endtask

    task automatic test_reset_mid_packet();
        req_valid = 1; req_dest = 4'd7; req_len = 4'd4;
        step();
        req_valid = 0; data_valid = 1; data_in = 32'h55;
        step();
        data_valid = 0;
        checks++; if (flit_out !== mk(2'b01, 32'h55)) begin errors++; $display("FAIL rm_body got %h want %h", flit_out, mk(2'b01, 32'h55)); end
        rst = 0;
        step();
        rst = 1;
        #1;
        checks++; if (flit_valid !== 1'b0 || flit_out !== '0) begin errors++; $display("FAIL rm_flit got %b/%h want 0/0", flit_valid, flit_out); end
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || dut.credit_cnt !== 3'd4) begin errors++; $display("FAIL rm_state got busy %b rdy %b cr %0d want 0 1 4", busy, req_ready, dut.credit_cnt); end
        req_valid = 1; req_dest = 4'd9; req_len = 4'd1;
        step();
        req_valid = 0; data_valid = 1; data_in = 32'h77;
        checks++; if (flit_out !== mk(2'b00, 32'h19)) begin errors++; $display("FAIL rm_head got %h want %h", flit_out, mk(2'b00, 32'h19)); end
        step();
        data_valid = 0;
        checks++; if (flit_valid !== 1'b1 || flit_out !== mk(2'b10, 32'h77)) begin errors++; $display("FAIL rm_tail got %b/%h want 1/%h", flit_valid, flit_out, mk(2'b10, 32'h77)); end
    endtask

    initial begin
        test_reset();
        test_multi_flit();
        test_back_to_back();
        test_credit_stall();
        test_credit_edges();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
